pixel_req_gen_lv10: RTL
=======================

# pixel_req_gen_lv10

Pixel-side request generator for one level-10 row group; it is the requester end of the round-robin row arbiter handshake. It latches per-row event pulses and their polarity, and drives a one-hot request vector to the arbiter. It retires a request when the arbiter's registered grant lands on it, then emits one decoded event (row index plus polarity) per accepted grant. A burst FSM pulses a refresh back to the arbiter once all pending requests have drained, so the next burst restarts the arbitration mask.

## Interface
- ROWS, 4, number of rows in the group (request/grant vector width)
- x_width, 2, width of the encoded row index; ROWS ≤ 2**x_width
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- enable_i  in  1  grant consumption enable; mirrors the arbiter's enable
- evt_i  in  ROWS  single-cycle event pulse per row
- pol_i  in  ROWS  event polarity per row, valid with evt_i
- gnt_i  in  ROWS  registered one-hot grant from the arbiter
- grp_release_i  in  1  arbiter round-wrap indication
- req_o  out  ROWS  pending requests to the arbiter
- refresh_o  out  1  one-cycle pulse: burst fully drained
- evt_valid_o  out  1  decoded event valid, one-cycle pulse
- evt_x_o  out  x_width  row index of the emitted event
- evt_pol_o  out  1  polarity of the emitted event
- overflow_o  out  1  one-cycle pulse: event dropped on an already-pending row
- spurious_o  out  1  one-cycle pulse: grant on a non-pending row, or a non-one-hot grant
- drop_cnt_o  out  16  saturating count of dropped events
- round_cnt_o  out  8  wrapping count of grp_release_i pulses seen while ACTIVE

## Operation
- Per row state is pend[i] and polr[i]. req_o = pend.
- Grant acceptance happens when enable_i=1 and gnt_i has a set bit.
  - k is the lowest set index. If pend[k]=1, the grant is accepted: clear pend[k], and on the next edge set evt_valid_o=1, evt_x_o=k, evt_pol_o=polr[k].
  - Any other set bit in gnt_i raises spurious_o and is otherwise ignored.
  - If pend[k]=0: spurious_o=1, no event is emitted, and state is unchanged.
- Event capture on row i with evt_i[i]=1 follows three cases:
  - pend[i]=0: set pend[i] and load polr[i]=pol_i[i].
  - pend[i]=1 and row i is accepted in the same cycle: the accepted event uses the old polr[i]. pend[i] stays 1 and polr[i] loads the new polarity, so the new event is not dropped.
  - pend[i]=1 with no acceptance: the new event is dropped. overflow_o=1, drop_cnt_o increments (saturates at 16'hFFFF), and polr[i] is kept.
- enable_i=0: grants are ignored (no acceptance and no spurious flag); event capture continues.
- Burst FSM:
  - IDLE: req_o==0. Go to ACTIVE when any row is pending.
  - ACTIVE: when the next pend is all zero, go to REFRESH.
  - REFRESH: refresh_o=1 for exactly this cycle. Next state is IDLE, or ACTIVE directly if any row became pending during REFRESH.
- round_cnt_o increments on grp_release_i only in ACTIVE and wraps at 8 bits.
- Multiple overflows in one cycle: overflow_o=1, and drop_cnt_o adds the popcount of dropped rows, saturating.

## Timing
- Reset values, all applied asynchronously:
  - pend and polr are 0, so req_o=0.
  - The FSM is in IDLE.
  - All pulse outputs are 0: refresh_o, evt_valid_o, overflow_o, spurious_o.
  - evt_x_o=0, evt_pol_o=0, drop_cnt_o=0, round_cnt_o=0.
- Every output is registered; evt_x_o and evt_pol_o hold their last value while evt_valid_o=0.
- Event-to-request latency: evt_i sampled at edge N gives req_o=1 after edge N.
- Grant-to-retire latency: gnt_i sampled at edge M gives pend cleared and evt_valid_o=1 after edge M.
- Throughput is one event per cycle under back-to-back grants.
- Last grant in a burst: accepted at edge M, the FSM enters REFRESH after M, refresh_o is high for the cycle after M, and the FSM is IDLE after M+1.
- Reset asserted mid-burst: all pending events are discarded, with no refresh_o and no evt_valid_o.

## Test plan
- ROWS=4, pulses on evt_i=4'b1010 with pol_i=4'b1000, then grants 4'b0010 and 4'b1000 on consecutive cycles.
  - req_o goes 4'b1010, 4'b1000, 0.
  - Events (x=1, pol=0) then (x=3, pol=1).
  - refresh_o pulses once, one cycle after the second event's grant edge.
- Row 2 pending, then a second evt_i[2] with no grant: overflow_o=1, drop_cnt_o=1, and polr[2] keeps its first value.
- Row 0 pending with pol 0; in the same cycle gnt_i=4'b0001 and evt_i[0]=1 with pol 1.
  - Event (x=0, pol=0) is emitted.
  - req_o[0] stays 1; the next grant emits pol=1.
- gnt_i=4'b0100 with pend[2]=0: spurious_o=1, no evt_valid_o, and req_o is unchanged. enable_i=0 with a valid grant: no acceptance.
- Force drop_cnt_o to 16'hFFFE, then drop 2 rows in one cycle: the count saturates at 16'hFFFF.
- Assert reset_i mid-burst with req_o=4'b0111: all outputs return to their reset values immediately, and there is no refresh_o after release.

Source files
------------

// File: rtl/pixel_req_gen_lv10_if.sv
// Requester/arbiter handshake bundle for the level-10 pixel request generator.
// The master modport is the requester side; slave is the arbiter/consumer side.
interface pixel_req_gen_lv10_if #(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned X_WIDTH = 2
);
  localparam int unsigned DROP_W  = 16;
  localparam int unsigned ROUND_W = 8;

  logic                enable_i;
  logic [ROWS-1:0]     evt_i;
  logic [ROWS-1:0]     pol_i;
  logic [ROWS-1:0]     gnt_i;
  logic                grp_release_i;
  logic [ROWS-1:0]     req_o;
  logic                refresh_o;
  logic                evt_valid_o;
  logic [X_WIDTH-1:0]  evt_x_o;
  logic                evt_pol_o;
  logic                overflow_o;
  logic                spurious_o;
  logic [DROP_W-1:0]   drop_cnt_o;
  logic [ROUND_W-1:0]  round_cnt_o;

  modport master (
    input  enable_i, evt_i, pol_i, gnt_i, grp_release_i,
    output req_o, refresh_o, evt_valid_o, evt_x_o, evt_pol_o,
           overflow_o, spurious_o, drop_cnt_o, round_cnt_o
  );

  modport slave (
    output enable_i, evt_i, pol_i, gnt_i, grp_release_i,
    input  req_o, refresh_o, evt_valid_o, evt_x_o, evt_pol_o,
           overflow_o, spurious_o, drop_cnt_o, round_cnt_o
  );
endinterface

// File: rtl/pixel_req_gen_lv10.sv
// Pixel-side request generator: latches row events, requests the row arbiter,
// retires granted rows into decoded events and pulses refresh when a burst drains.
module pixel_req_gen_lv10 #(
  parameter int unsigned ROWS    = 4,
  parameter int unsigned X_WIDTH = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  pixel_req_gen_lv10_if.master bus
);
  localparam int unsigned CNT_W   = $clog2(ROWS + 1);
  localparam int unsigned DROP_W  = 16;
  localparam int unsigned ROUND_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_REFRESH} state_e;

  state_e               state_q, state_d;
  logic [ROWS-1:0]      pend_q, pend_d;
  logic [ROWS-1:0]      polr_q, polr_d;
  logic                 refresh_q, refresh_d;
  logic                 evt_valid_q, evt_valid_d;
  logic [X_WIDTH-1:0]   evt_x_q, evt_x_d;
  logic                 evt_pol_q, evt_pol_d;
  logic                 overflow_q, overflow_d;
  logic                 spurious_q, spurious_d;
  logic [DROP_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic [ROUND_W-1:0]   round_cnt_q, round_cnt_d;

  logic                 gnt_seen;
  logic                 gnt_multi;
  logic                 accept;
  logic [X_WIDTH-1:0]   gnt_idx;
  logic [ROWS-1:0]      drop_rows;
  logic [CNT_W-1:0]     drop_num;
  logic [DROP_W:0]      drop_sum;

  // Grant decode: lowest set bit wins, extra bits only flag as spurious
  always_comb begin
    gnt_seen  = bus.enable_i && (bus.gnt_i != '0);
    gnt_multi = (bus.gnt_i & (bus.gnt_i - ROWS'(1))) != '0;
    gnt_idx   = '0;
    for (int i = int'(ROWS) - 1; i >= 0; i--) begin
      if (bus.gnt_i[i]) gnt_idx = X_WIDTH'(i);
    end
    accept = gnt_seen && pend_q[gnt_idx];
  end

  // Row bookkeeping, event emission and drop accounting
  always_comb begin
    pend_d      = pend_q;
    polr_d      = polr_q;
    drop_rows   = '0;
    drop_num    = '0;
    evt_valid_d = accept;
    evt_x_d     = evt_x_q;
    evt_pol_d   = evt_pol_q;
    spurious_d  = gnt_seen && (!pend_q[gnt_idx] || gnt_multi);
    if (accept) begin
      pend_d[gnt_idx] = 1'b0;
      evt_x_d         = gnt_idx;
      evt_pol_d       = polr_q[gnt_idx];
    end
    for (int i = 0; i < int'(ROWS); i++) begin
      if (bus.evt_i[i]) begin
        // A row retired this cycle can take a new event without dropping it
        if (!pend_q[i] || (accept && (gnt_idx == X_WIDTH'(i)))) begin
          pend_d[i] = 1'b1;
          polr_d[i] = bus.pol_i[i];
        end else begin
          drop_rows[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < int'(ROWS); i++) begin
      drop_num = drop_num + CNT_W'(drop_rows[i]);
    end
    drop_sum   = {1'b0, drop_cnt_q} + (DROP_W+1)'(drop_num);
    overflow_d = drop_rows != '0;
    drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  // Burst FSM next state
  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_d != '0) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (pend_d == '0) state_d = ST_REFRESH;
        if (bus.grp_release_i) round_cnt_d = round_cnt_q + ROUND_W'(1);
      end
      ST_REFRESH: begin
        state_d = (pend_d != '0) ? ST_ACTIVE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    refresh_d = (state_d == ST_REFRESH);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      polr_q      <= '0;
      refresh_q   <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_x_q     <= '0;
      evt_pol_q   <= 1'b0;
      overflow_q  <= 1'b0;
      spurious_q  <= 1'b0;
      drop_cnt_q  <= '0;
      round_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      polr_q      <= polr_d;
      refresh_q   <= refresh_d;
      evt_valid_q <= evt_valid_d;
      evt_x_q     <= evt_x_d;
      evt_pol_q   <= evt_pol_d;
      overflow_q  <= overflow_d;
      spurious_q  <= spurious_d;
      drop_cnt_q  <= drop_cnt_d;
      round_cnt_q <= round_cnt_d;
    end
  end

  assign bus.req_o       = pend_q;
  assign bus.refresh_o   = refresh_q;
  assign bus.evt_valid_o = evt_valid_q;
  assign bus.evt_x_o     = evt_x_q;
  assign bus.evt_pol_o   = evt_pol_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.spurious_o  = spurious_q;
  assign bus.drop_cnt_o  = drop_cnt_q;
  assign bus.round_cnt_o = round_cnt_q;
endmodule
